// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops words from an upstream word FIFO and drains each
// one MSB-first as a byte stream on a valid/ready interface.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for the FIFO to report data
//   S_POP  | single-cycle pop request to the FIFO
//   S_CAPT | FIFO data_out holds the popped word, load shift register
//   S_SEND | presenting bytes, advancing on each valid/ready handshake
module fifo_byte_serializer #(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   output logic              fifo_pop,
   input  logic [DATA_W-1:0] fifo_data,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count
);

   localparam int NB    = DATA_W / BYTE_W;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_CAPT = 2'd2,
      S_SEND = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Next-state, shift register, byte index and completed-word counter.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_POP;
         end
         S_POP: begin
            state_d = S_CAPT;
         end
         S_CAPT: begin
            shreg_d = fifo_data;
            idx_d   = '0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (byte_ready) begin
               shreg_d = shreg_q << BYTE_W;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  cnt_d   = cnt_q + CNT_W'(1);
                  // Empty flag is only consulted here, so mid-word changes are ignored.
                  state_d = fifo_empty ? S_IDLE : S_POP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are decoded purely from registered state so they drop at reset immediately.
   assign fifo_pop   = (state_q == S_POP);
   assign byte_valid = (state_q == S_SEND);
   assign byte_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
   assign busy       = (state_q != S_IDLE);
   assign byte_out   = shreg_q[DATA_W-1 -: BYTE_W];
   assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer with a small word-FIFO model.
module tb_fifo_byte_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic        fifo_pop;
   logic [31:0] fifo_data = '0;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready = 1'b1;
   logic        byte_last;
   logic        busy;
   logic [15:0] word_count;

   logic        push_req = 1'b0;
   logic [31:0] push_word = '0;
   logic [31:0] fq[$];

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int last_pop_cyc = 0;
   logic [7:0] rx_byte[$];
   logic       rx_last[$];
   int         rx_cyc[$];

   fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .fifo_data  (fifo_data),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_last  (byte_last),
      .busy       (busy),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Word FIFO model: data_out is registered on a sampled pop, empty flag is registered.
   always @(posedge clk) begin
      if (fifo_pop && fq.size() != 0) fifo_data <= fq.pop_front();
      if (push_req) fq.push_back(push_word);
      fifo_empty <= (fq.size() == 0);
   end

   // Records pops and accepted bytes with the cycle they happened in.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_pop) begin
         pop_cnt      <= pop_cnt + 1;
         last_pop_cyc <= cyc;
      end
      if (byte_valid && byte_ready) begin
         rx_byte.push_back(byte_out);
         rx_last.push_back(byte_last);
         rx_cyc.push_back(cyc);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Called at a negedge; leaves the bench at the following negedge.
   task automatic push(input logic [31:0] w);
      push_req  = 1'b1;
      push_word = w;
      @(negedge clk);
      push_req  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_rx(input int n, input int lim);
      int k = 0;
      while (rx_byte.size() < n && k < lim) begin
         @(negedge clk);
         k++;
      end
      check_eq("wait_rx_count", rx_byte.size(), n);
   endtask

   logic [7:0] exp2 [4]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
   logic [7:0] exp3 [16] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE,
                             8'hFE, 8'hED, 8'hFA, 8'hCE, 8'hBA, 8'hAD, 8'hF0, 8'h0D};
   logic       pat4  [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [7:0] held4 [7]  = '{8'hCA, 8'hFE, 8'hFE, 8'hFE, 8'hBA, 8'hBA, 8'hBE};
   logic [7:0] exp4  [4]  = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
   logic [7:0] exp5  [4]  = '{8'hFE, 8'hED, 8'hFA, 8'hCE};
   logic [7:0] exp6  [4]  = '{8'h12, 8'h34, 8'h56, 8'h78};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, b2, p0, bad, k;

      // Reset, then idle with an empty FIFO.
      repeat (3) @(negedge clk);
      check_eq("rst_valid", byte_valid, 1'b0);
      check_eq("rst_byte_out", byte_out, 8'h00);
      rst = 1'b0;
      p0  = pop_cnt;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (byte_valid || busy || fifo_pop) bad++;
      end
      check_eq("t1_pops", pop_cnt - p0, 0);
      check_eq("t1_active_cycles", bad, 0);
      check_eq("t1_busy", busy, 1'b0);
      check_eq("t1_word_count", word_count, 16'd0);

      // Single word, sink always ready.
      b  = rx_byte.size();
      p0 = pop_cnt;
      push(32'hDEADBEEF);
      wait_rx(b + 4, 40);
      for (int i = 0; i < 4; i++) begin
         check_eq("t2_byte", rx_byte[b+i], exp2[i]);
         check_eq("t2_last", rx_last[b+i], (i == 3) ? 1'b1 : 1'b0);
      end
      check_eq("t2_consecutive", rx_cyc[b+3] - rx_cyc[b], 3);
      check_eq("t2_pop_to_byte", rx_cyc[b] - last_pop_cyc, 2);
      repeat (2) @(negedge clk);
      check_eq("t2_pops", pop_cnt - p0, 1);
      check_eq("t2_word_count", word_count, 16'd1);
      check_eq("t2_idle", busy, 1'b0);

      // Four words back to back.
      do_reset();
      b  = rx_byte.size();
      p0 = pop_cnt;
      push(32'hDEADBEEF);
      push(32'hCAFEBABE);
      push(32'hFEEDFACE);
      push(32'hBAADF00D);
      wait_rx(b + 16, 200);
      for (int i = 0; i < 16; i++) begin
         check_eq("t3_byte", rx_byte[b+i], exp3[i]);
         check_eq("t3_last", rx_last[b+i], (i % 4 == 3) ? 1'b1 : 1'b0);
      end
      for (int w = 1; w < 4; w++)
         check_eq("t3_word_gap", rx_cyc[b+4*w] - rx_cyc[b+4*w-1], 3);
      repeat (3) @(negedge clk);
      check_eq("t3_pops", pop_cnt - p0, 4);
      check_eq("t3_word_count", word_count, 16'd4);
      check_eq("t3_idle", busy, 1'b0);

      // Backpressure.
      do_reset();
      byte_ready = 1'b0;
      b = rx_byte.size();
      push(32'hCAFEBABE);
      k = 0;
      while (!byte_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("t4_valid_seen", byte_valid, 1'b1);
      for (int i = 0; i < 7; i++) begin
         byte_ready = pat4[i];
         check_eq("t4_held_byte", byte_out, held4[i]);
         check_eq("t4_held_valid", byte_valid, 1'b1);
         check_eq("t4_held_last", byte_last, (i == 6) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      byte_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("t4_count", rx_byte.size(), b + 4);
      for (int i = 0; i < 4; i++) check_eq("t4_byte", rx_byte[b+i], exp4[i]);
      check_eq("t4_word_count", word_count, 16'd1);

      // Reset in the middle of a word.
      do_reset();
      b = rx_byte.size();
      push(32'hDEADBEEF);
      wait_rx(b + 2, 40);
      rst = 1'b1;
      #1;
      check_eq("t5_valid", byte_valid, 1'b0);
      check_eq("t5_pop", fifo_pop, 1'b0);
      check_eq("t5_busy", busy, 1'b0);
      check_eq("t5_byte_out", byte_out, 8'h00);
      check_eq("t5_last", byte_last, 1'b0);
      check_eq("t5_word_count", word_count, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      b2 = rx_byte.size();
      check_eq("t5_partial_dropped", b2, b + 2);
      push(32'hFEEDFACE);
      wait_rx(b2 + 4, 40);
      for (int i = 0; i < 4; i++) check_eq("t5_byte", rx_byte[b2+i], exp5[i]);
      @(negedge clk);
      check_eq("t5_word_count_after", word_count, 16'd1);

      // Counter wrap.
      do_reset();
      force dut.cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_q;
      @(negedge clk);
      check_eq("t6_preset", word_count, 16'hFFFF);
      b = rx_byte.size();
      push(32'h12345678);
      wait_rx(b + 4, 40);
      for (int i = 0; i < 4; i++) check_eq("t6_byte", rx_byte[b+i], exp6[i]);
      @(negedge clk);
      check_eq("t6_wrap", word_count, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
